// File: rtl/ex_stage.sv
// Two-stage execute pipeline: S1 holds operands for the core ALU, S2 holds the result for writeback.
// Valid/ready on both sides, with optional forwarding from the in-flight S1/S2 results.

module ex_alu (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    // Combinational core ALU. Compares are unsigned and produce 0 or 1.
    always_comb begin
        y = 32'd0;
        case (op)
            4'd0:    y = a + b;
            4'd1:    y = a - b;
            4'd2:    y = a & b;
            4'd3:    y = a | b;
            4'd4:    y = a ^ b;
            4'd5:    y = {31'd0, (a < b)};
            4'd6:    y = {31'd0, (a > b)};
            default: y = 32'd0;
        endcase
    end

endmodule

module ex_stage #(
    parameter int FWD_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [4:0]  in_rd,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_illegal
);

    logic        s1_valid;
    logic [3:0]  s1_op;
    logic [31:0] s1_num1;
    logic [31:0] s1_num2;
    logic [4:0]  s1_rd;
    logic        s1_illegal;

    logic        s2_valid;
    logic [31:0] s2_result;
    logic [4:0]  s2_rd;
    logic        s2_illegal;

    logic        s2_adv;
    logic        accept;
    logic [31:0] alu_y;
    logic [31:0] s1_result;

    logic        fwd_on;
    logic        rs1_hit_s1;
    logic        rs1_hit_s2;
    logic        rs2_hit_s1;
    logic        rs2_hit_s2;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic [31:0] num1_next;
    logic [31:0] num2_next;

    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    ex_alu u_alu (
        .op (s1_op),
        .a  (s1_num1),
        .b  (s1_num2),
        .y  (alu_y)
    );

    // Illegal ops yield zero both at writeback and when forwarded to a consumer.
    assign s1_result = s1_illegal ? 32'd0 : alu_y;

    assign fwd_on     = (FWD_EN != 0);
    assign rs1_hit_s1 = fwd_on && s1_valid && (s1_rd != 5'd0) && (s1_rd == in_rs1);
    assign rs1_hit_s2 = fwd_on && s2_valid && (s2_rd != 5'd0) && (s2_rd == in_rs1);
    assign rs2_hit_s1 = fwd_on && s1_valid && (s1_rd != 5'd0) && (s1_rd == in_rs2);
    assign rs2_hit_s2 = fwd_on && s2_valid && (s2_rd != 5'd0) && (s2_rd == in_rs2);

    // The youngest producer (S1) wins over the older one in S2.
    always_comb begin
        rs1_fwd = in_rs1_val;
        if (rs1_hit_s1) begin
            rs1_fwd = s1_result;
        end else if (rs1_hit_s2) begin
            rs1_fwd = s2_result;
        end

        rs2_fwd = in_rs2_val;
        if (rs2_hit_s1) begin
            rs2_fwd = s1_result;
        end else if (rs2_hit_s2) begin
            rs2_fwd = s2_result;
        end
    end

    assign num1_next = rs1_fwd;
    assign num2_next = in_use_imm ? in_imm : rs2_fwd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_op      <= 4'd0;
            s1_num1    <= 32'd0;
            s1_num2    <= 32'd0;
            s1_rd      <= 5'd0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_op      <= in_op;
            s1_num1    <= num1_next;
            s1_num2    <= num2_next;
            s1_rd      <= in_rd;
            s1_illegal <= (in_op > 4'd6);
        end else if (s1_valid && s2_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // S2 only changes when it is empty or its result is being taken this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_result  <= 32'd0;
            s2_rd      <= 5'd0;
            s2_illegal <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result  <= s1_result;
                s2_rd      <= s1_rd;
                s2_illegal <= s1_illegal;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_rd      = s2_rd;
    assign out_result  = s2_result;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized run against a
// transaction-level model, with one forwarding and one non-forwarding instance in parallel.

module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic        out_ready;

    logic        f_in_ready, n_in_ready;
    logic        f_out_valid, n_out_valid;
    logic [4:0]  f_out_rd, n_out_rd;
    logic [31:0] f_out_result, n_out_result;
    logic        f_out_illegal, n_out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res_f;
        logic [31:0] res_n;
        logic        ill;
        int          age;
    } item_t;

    item_t q[$];

    ex_stage #(.FWD_EN(1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_rd(f_out_rd),
        .out_result(f_out_result), .out_illegal(f_out_illegal)
    );

    ex_stage #(.FWD_EN(0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_rd(n_out_rd),
        .out_result(n_out_result), .out_illegal(n_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (a < b) ? 32'd1 : 32'd0;
            4'd6:    return (a > b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Value of a source register as seen by a new instruction: newest in-flight writer, else regfile.
    function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] regval);
        if (rs != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == rs) return q[i].res_f;
            end
        end
        return regval;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                         input logic [31:0] rs1v, input logic [4:0] rs2, input logic [31:0] rs2v,
                         input logic [31:0] imm, input logic ui, input logic [4:0] rd);
        in_valid   = v;
        in_op      = op;
        in_rs1     = rs1;
        in_rs1_val = rs1v;
        in_rs2     = rs2;
        in_rs2_val = rs2v;
        in_imm     = imm;
        in_use_imm = ui;
        in_rd      = rd;
    endtask

    task automatic idle;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic do_reset;
        idle();
        out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++;
        if ({f_out_valid, f_in_ready, f_out_rd, f_out_result, f_out_illegal} !==
            {1'b0, 1'b1, 5'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_f: got v=%b r=%b rd=%0d res=%h ill=%b, want 0 1 0 0 0",
                     f_out_valid, f_in_ready, f_out_rd, f_out_result, f_out_illegal);
        end
        n_tests++;
        if ({n_out_valid, n_in_ready, n_out_rd, n_out_result, n_out_illegal} !==
            {1'b0, 1'b1, 5'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_n: got v=%b r=%b rd=%0d res=%h ill=%b, want 0 1 0 0 0",
                     n_out_valid, n_in_ready, n_out_rd, n_out_result, n_out_illegal);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        drive(1'b1, 4'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd1, 1'b1, 5'd5);
        tick();
        idle();
        #1;
        n_tests++;
        if (f_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wrap_latency: out_valid=%b after one edge, want 0", f_out_valid);
        end
        tick();
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result, f_out_illegal} !== {1'b1, 5'd5, 32'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL wrap_add: got v=%b rd=%0d res=%h ill=%b, want 1 5 00000000 0",
                     f_out_valid, f_out_rd, f_out_result, f_out_illegal);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        drive(1'b1, 4'd0, 5'd10, 32'd3, 5'd11, 32'd4, 32'd0, 1'b0, 5'd1);
        tick();
        drive(1'b1, 4'd1, 5'd1, 32'd0, 5'd12, 32'd2, 32'd0, 1'b0, 5'd2);
        #1;
        n_tests++;
        if ({f_in_ready, f_out_valid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL b2b_ready: got ready=%b valid=%b, want 1 0", f_in_ready, f_out_valid);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result, n_out_result} !== {1'b1, 5'd1, 32'd7, 32'd7}) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got v=%b rd=%0d f=%h n=%h, want 1 1 7 7",
                     f_out_valid, f_out_rd, f_out_result, n_out_result);
        end
        tick();
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result} !== {1'b1, 5'd2, 32'd5}) begin
            n_fail++;
            $display("[TB] FAIL b2b_s1_fwd: got v=%b rd=%0d res=%h, want 1 2 5",
                     f_out_valid, f_out_rd, f_out_result);
        end
        n_tests++;
        if (n_out_result !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("[TB] FAIL b2b_nofwd: got %h, want fffffffe", n_out_result);
        end
    endtask

    task automatic test_s2_forward;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd0, 32'h10, 5'd0, 32'd0, 32'd0, 1'b1, 5'd3);
        tick();
        idle();
        tick();
        drive(1'b1, 4'd3, 5'd3, 32'd0, 5'd0, 32'd0, 32'h01, 1'b1, 5'd6);
        #1;
        n_tests++;
        if (f_in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL s2fwd_ready: got %b, want 1", f_in_ready);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result, f_in_ready} !== {1'b1, 5'd3, 32'h10, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL s2fwd_hold: got v=%b rd=%0d res=%h ready=%b, want 1 3 10 0",
                     f_out_valid, f_out_rd, f_out_result, f_in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result} !== {1'b1, 5'd6, 32'h11}) begin
            n_fail++;
            $display("[TB] FAIL s2fwd_result: got v=%b rd=%0d res=%h, want 1 6 11",
                     f_out_valid, f_out_rd, f_out_result);
        end
        n_tests++;
        if (n_out_result !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL s2fwd_nofwd: got %h, want 01", n_out_result);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        drive(1'b1, 4'd9, 5'd5, 32'd123, 5'd6, 32'd9, 32'd0, 1'b0, 5'd4);
        tick();
        drive(1'b1, 4'd0, 5'd4, 32'h55, 5'd0, 32'd7, 32'd0, 1'b0, 5'd7);
        tick();
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result, f_out_illegal, n_out_illegal} !==
            {1'b1, 5'd4, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL illegal_op: got v=%b rd=%0d res=%h ill=%b/%b, want 1 4 0 1/1",
                     f_out_valid, f_out_rd, f_out_result, f_out_illegal, n_out_illegal);
        end
        drive(1'b1, 4'd0, 5'd0, 32'd1, 5'd0, 32'd0, 32'd99, 1'b1, 5'd0);
        tick();
        n_tests++;
        if ({f_out_rd, f_out_result, f_out_illegal, n_out_result} !==
            {5'd7, 32'd7, 1'b0, 32'h5C}) begin
            n_fail++;
            $display("[TB] FAIL illegal_fwd: got rd=%0d f=%h ill=%b n=%h, want 7 7 0 5c",
                     f_out_rd, f_out_result, f_out_illegal, n_out_result);
        end
        drive(1'b1, 4'd0, 5'd0, 32'h20, 5'd0, 32'd0, 32'd1, 1'b1, 5'd8);
        tick();
        idle();
        n_tests++;
        if ({f_out_valid, f_out_rd, f_out_result} !== {1'b1, 5'd0, 32'd100}) begin
            n_fail++;
            $display("[TB] FAIL rd0_flow: got v=%b rd=%0d res=%0d, want 1 0 100",
                     f_out_valid, f_out_rd, f_out_result);
        end
        tick();
        n_tests++;
        if ({f_out_rd, f_out_result} !== {5'd8, 32'h21}) begin
            n_fail++;
            $display("[TB] FAIL rs0_nofwd: got rd=%0d res=%h, want 8 21", f_out_rd, f_out_result);
        end
    endtask

    task automatic test_stall_reset;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd0, 32'h11, 5'd0, 32'd0, 32'h22, 1'b1, 5'd9);
        tick();
        drive(1'b1, 4'd4, 5'd0, 32'hF0, 5'd0, 32'd0, 32'hFF, 1'b1, 5'd10);
        tick();
        drive(1'b1, 4'd0, 5'd0, 32'h1, 5'd0, 32'd0, 32'h1, 1'b1, 5'd11);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({f_in_ready, n_in_ready, f_out_valid, f_out_rd, f_out_result, f_out_illegal} !==
                {1'b0, 1'b0, 1'b1, 5'd9, 32'h33, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL stall_hold[%0d]: got r=%b/%b v=%b rd=%0d res=%h, want 0/0 1 9 33",
                         i, f_in_ready, n_in_ready, f_out_valid, f_out_rd, f_out_result);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        n_tests++;
        if ({f_out_valid, f_in_ready, f_out_rd, f_out_result, f_out_illegal} !==
            {1'b0, 1'b1, 5'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL stall_reset: got v=%b r=%b rd=%0d res=%h ill=%b, want 0 1 0 0 0",
                     f_out_valid, f_in_ready, f_out_rd, f_out_result, f_out_illegal);
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({f_out_valid, n_out_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL stall_discard: got v=%b/%b, want 0/0", f_out_valid, n_out_valid);
        end
    endtask

    task automatic test_random;
        logic        exp_ready;
        logic        exp_ov;
        logic        in_fire;
        logic        out_fire;
        logic [31:0] a_f, b_f, a_n, b_n;
        logic [3:0]  op;
        item_t       it;
        int          n;
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            drive($urandom_range(0, 3) != 0, op, 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20)),
                  $urandom, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            n = q.size();
            exp_ready = !(n == 2 && !out_ready);
            exp_ov    = (n == 2) || (n == 1 && q[0].age >= 2);
            n_tests++;
            if ({f_in_ready, n_in_ready, f_out_valid, n_out_valid} !== {exp_ready, exp_ready, exp_ov, exp_ov}) begin
                n_fail++;
                $display("[TB] FAIL rand_hs[%0d]: got r=%b/%b v=%b/%b, want r=%b v=%b",
                         cyc, f_in_ready, n_in_ready, f_out_valid, n_out_valid, exp_ready, exp_ov);
            end
            if (exp_ov) begin
                n_tests++;
                if ({f_out_rd, f_out_result, f_out_illegal, n_out_rd, n_out_result, n_out_illegal} !==
                    {q[0].rd, q[0].res_f, q[0].ill, q[0].rd, q[0].res_n, q[0].ill}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_data[%0d]: got rd=%0d f=%h n=%h ill=%b/%b, want rd=%0d f=%h n=%h ill=%b",
                             cyc, f_out_rd, f_out_result, n_out_result, f_out_illegal, n_out_illegal,
                             q[0].rd, q[0].res_f, q[0].res_n, q[0].ill);
                end
            end
            in_fire  = in_valid && exp_ready;
            out_fire = exp_ov && out_ready;
            if (in_fire) begin
                a_f = fwd_val(in_rs1, in_rs1_val);
                b_f = in_use_imm ? in_imm : fwd_val(in_rs2, in_rs2_val);
                a_n = in_rs1_val;
                b_n = in_use_imm ? in_imm : in_rs2_val;
                it.rd    = in_rd;
                it.ill   = (in_op > 4'd6);
                it.res_f = ref_alu(in_op, a_f, b_f);
                it.res_n = ref_alu(in_op, a_n, b_n);
                it.age   = 1;
            end
            @(posedge clk);
            if (out_fire) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_fire) q.push_back(it);
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();
        tick();
        test_reset();
        test_wrap();
        test_back_to_back();
        test_s2_forward();
        test_illegal();
        test_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, enables operand forwarding (0 = operands taken only from input ports).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 in_valid  input  1  upstream (decode) presents an instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_op  input  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 unsigned less-than, 6 unsigned greater-than.
REQ-007 in_rs1, in_rs2  input  5 each  source register indices.
REQ-008 in_rs1_val, in_rs2_val  input  32 each  register-file read values.
REQ-009 in_imm  input  32  immediate operand.
REQ-010 in_use_imm  input  1  1 = num2 is in_imm, 0 = num2 is the rs2 operand.
REQ-011 in_rd  input  5  destination register index.
REQ-012 out_valid  output  1  result presented to writeback.
REQ-013 out_ready  input  1  writeback accepts the result.
REQ-014 out_rd  output  5  destination index of the presented result.
REQ-015 out_result  output  32  ALU result.
REQ-016 out_illegal  output  1  presented instruction had op 7-15.

Function
REQ-017 Two registered stages: S1 (op, num1, num2, rd, illegal, valid), S2 (result, rd, illegal, valid); S2 drives the out_* ports directly.
REQ-018 Handshakes: transfer on in_valid&&in_ready and on out_valid&&out_ready; out_* held stable while out_valid&&!out_ready.
REQ-019 s2_adv = !s2_valid || out_ready; in_ready = !s1_valid || s2_adv (combinational, full throughput, no bubble on back-to-back).
REQ-020 Latency: instruction accepted at edge N appears with out_valid=1 after edge N+1 when unstalled (2 cycles accept-to-output).
REQ-021 S1 contents move to S2 when s1_valid && s2_adv; S1 loads on accept; S1 valid clears when it advances without a new accept.
REQ-022 S1 feeds an instantiated core ALU; result for op 0-6 equals that ALU's definition, 32-bit wrap on add/sub, compares unsigned yielding 0 or 1.
REQ-023 Op 7-15: S2 result forced to 0, out_illegal=1, instruction still flows and handshakes normally.
REQ-024 Operand forwarding (FWD_EN=1), evaluated at accept per source: if S1 valid, S1 rd!=0, S1 rd==rs then use current S1 ALU output; else if S2 valid, S2 rd!=0, S2 rd==rs then use out_result; else use in_rsN_val.
REQ-025 S1 forwarding has priority over S2 (youngest producer wins).
REQ-026 Forwarding never applies to rs==0; rd==0 results still flow to writeback unchanged.
REQ-027 Illegal-op producer: forwarded value is 0 (consistent with REQ-023).
REQ-028 num2 = in_imm when in_use_imm=1 regardless of rs2 forwarding match.
REQ-029 Stall with full pipe: S1 and S2 both hold, in_ready=0; no instruction dropped or duplicated.
REQ-030 Simultaneous S2 drain and S1 advance and new accept in one cycle shall be supported.

Reset
REQ-031 rst_n=0 at a rising edge clears s1_valid and s2_valid; out_valid=0, in_ready=1 in the following cycle.
REQ-032 Reset also clears out_rd=0, out_result=0, out_illegal=0; in-flight instructions are discarded.
REQ-033 Reset mid-stall takes priority over all handshake updates.

Verification
REQ-034 Accept op 0, rs1_val=0xFFFFFFFF, imm=1, use_imm=1, rd=5, out_ready=1 -> two cycles later out_valid=1, out_rd=5, out_result=0x00000000.
REQ-035 Back-to-back: add x1=3+4 (rd=1) then sub rd=2 rs1=1 (in_rs1_val stale 0) rs2_val=2 -> results 7 then 5 (S1 forward), one result per cycle.
REQ-036 Producer x3 = 0x10 in S2 stalled (out_ready=0), consumer or rs1=3 imm=0x01 -> after release result 0x11 (S2 forward); with FWD_EN=0 result 0x01.
REQ-037 op 9, any operands, rd=4 -> out_result=0, out_illegal=1; dependent rs1=4 consumer sees 0; rs=0 with S1 rd=0 -> no forwarding, in_rs1_val used.
REQ-038 Fill pipe, hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable; assert rst_n=0 one cycle -> out_valid=0, in_ready=1, outputs zero next cycle.
